// File: rtl/store_pixel_block_pkg.sv
// Shared constants and FSM encoding for the 4x4 pixel block store and load paths.
package store_pixel_block_pkg;
  localparam int BLOCK_DIM    = 4;
  localparam int BLOCK_PIXELS = BLOCK_DIM * BLOCK_DIM;
  localparam int DIM_W        = $clog2(BLOCK_DIM);
  localparam int IDX_W        = $clog2(BLOCK_PIXELS);
  localparam int PIXEL_W      = 9;
  localparam int COORD_W      = 8;
  localparam int ADDR_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/block_addr_gen.sv
// Maps a pixel index within a 4x4 block plus the block coordinates to a frame
// hcount/vcount pair; results wrap silently at ADDR_W.
module block_addr_gen #(
  parameter int COORD_W = store_pixel_block_pkg::COORD_W,
  parameter int ADDR_W  = store_pixel_block_pkg::ADDR_W
) (
  input  logic [store_pixel_block_pkg::IDX_W-1:0] idx_i,
  input  logic [COORD_W-1:0]                      block_x_i,
  input  logic [COORD_W-1:0]                      block_y_i,
  output logic [ADDR_W-1:0]                       hcount_o,
  output logic [ADDR_W-1:0]                       vcount_o
);
  import store_pixel_block_pkg::*;

  logic [COORD_W+DIM_W-1:0] h_full;
  logic [COORD_W+DIM_W-1:0] v_full;

  // The low bits of (coord << 2) are zero, so concatenation is the add.
  always_comb begin
    h_full = {block_x_i, idx_i[DIM_W-1:0]};
    v_full = {block_y_i, idx_i[IDX_W-1:DIM_W]};
  end

  assign hcount_o = ADDR_W'(h_full);
  assign vcount_o = ADDR_W'(v_full);
endmodule

// File: rtl/store_pixel_block.sv
// Captures one 4x4 pixel block on start and writes it to frame memory one
// pixel per cycle in row-major order, gated by a per-pixel write mask.
module store_pixel_block #(
  parameter int PIXEL_W = store_pixel_block_pkg::PIXEL_W,
  parameter int COORD_W = store_pixel_block_pkg::COORD_W,
  parameter int ADDR_W  = store_pixel_block_pkg::ADDR_W
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           start,
  input  logic [COORD_W-1:0]                             block_x,
  input  logic [COORD_W-1:0]                             block_y,
  input  logic [PIXEL_W-1:0]                             pixel_0,
  input  logic [PIXEL_W-1:0]                             pixel_1,
  input  logic [PIXEL_W-1:0]                             pixel_2,
  input  logic [PIXEL_W-1:0]                             pixel_3,
  input  logic [PIXEL_W-1:0]                             pixel_4,
  input  logic [PIXEL_W-1:0]                             pixel_5,
  input  logic [PIXEL_W-1:0]                             pixel_6,
  input  logic [PIXEL_W-1:0]                             pixel_7,
  input  logic [PIXEL_W-1:0]                             pixel_8,
  input  logic [PIXEL_W-1:0]                             pixel_9,
  input  logic [PIXEL_W-1:0]                             pixel_a,
  input  logic [PIXEL_W-1:0]                             pixel_b,
  input  logic [PIXEL_W-1:0]                             pixel_c,
  input  logic [PIXEL_W-1:0]                             pixel_d,
  input  logic [PIXEL_W-1:0]                             pixel_e,
  input  logic [PIXEL_W-1:0]                             pixel_f,
  input  logic [store_pixel_block_pkg::BLOCK_PIXELS-1:0] write_mask,
  output logic [ADDR_W-1:0]                              mem_hcount,
  output logic [ADDR_W-1:0]                              mem_vcount,
  output logic [PIXEL_W-1:0]                             mem_data,
  output logic                                           mem_we,
  output logic                                           busy,
  output logic                                           done
);
  import store_pixel_block_pkg::*;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      capture;
  logic [COORD_W-1:0]        bx_q, by_q;
  logic [BLOCK_PIXELS-1:0]   mask_q;
  logic [PIXEL_W-1:0]        pix_q [BLOCK_PIXELS];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(BLOCK_PIXELS - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Block payload registers carry no reset; they are only read in WRITE.
  always_ff @(posedge clk) begin
    if (capture) begin
      bx_q   <= block_x;
      by_q   <= block_y;
      mask_q <= write_mask;
      pix_q  <= '{pixel_0, pixel_1, pixel_2, pixel_3, pixel_4, pixel_5, pixel_6, pixel_7,
                  pixel_8, pixel_9, pixel_a, pixel_b, pixel_c, pixel_d, pixel_e, pixel_f};
    end
  end

  block_addr_gen #(
    .COORD_W (COORD_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .idx_i     (idx_q),
    .block_x_i (bx_q),
    .block_y_i (by_q),
    .hcount_o  (mem_hcount),
    .vcount_o  (mem_vcount)
  );

  assign mem_data = pix_q[idx_q];
  assign mem_we   = (state_q == ST_WRITE) && mask_q[idx_q];
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_store_pixel_block.sv
// Randomized bench for store_pixel_block against a per-block write-list model.
module tb_store_pixel_block;
  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  drv_bx, drv_by;
  logic [8:0]  drv_pix [16];
  logic [15:0] drv_mask;
  logic [9:0]  mem_hcount, mem_vcount;
  logic [8:0]  mem_data;
  logic        mem_we, busy, done;

  int errors = 0;
  int checks = 0;

  // Golden copy of the block currently being written.
  int          op_bx, op_by;
  int          op_pix [16];
  logic [15:0] op_mask;

  store_pixel_block dut (
    .clk(clk), .reset(reset), .start(start),
    .block_x(drv_bx), .block_y(drv_by),
    .pixel_0(drv_pix[0]),  .pixel_1(drv_pix[1]),  .pixel_2(drv_pix[2]),  .pixel_3(drv_pix[3]),
    .pixel_4(drv_pix[4]),  .pixel_5(drv_pix[5]),  .pixel_6(drv_pix[6]),  .pixel_7(drv_pix[7]),
    .pixel_8(drv_pix[8]),  .pixel_9(drv_pix[9]),  .pixel_a(drv_pix[10]), .pixel_b(drv_pix[11]),
    .pixel_c(drv_pix[12]), .pixel_d(drv_pix[13]), .pixel_e(drv_pix[14]), .pixel_f(drv_pix[15]),
    .write_mask(drv_mask),
    .mem_hcount(mem_hcount), .mem_vcount(mem_vcount), .mem_data(mem_data),
    .mem_we(mem_we), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    drv_bx   = 8'($urandom);
    drv_by   = 8'($urandom);
    drv_mask = 16'($urandom);
    for (int i = 0; i < 16; i++) drv_pix[i] = 9'($urandom);
  endtask

  task automatic rand_op();
    op_bx = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
    op_by = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
    case ($urandom_range(0, 5))
      0:       op_mask = 16'h0000;
      1:       op_mask = 16'hFFFF;
      default: op_mask = 16'($urandom);
    endcase
    for (int i = 0; i < 16; i++) op_pix[i] = $urandom_range(0, 511);
  endtask

  // Launch the op held in op_* from an idle cycle and check all 17 busy cycles.
  // Returns in the cycle after DONE, or in an idle cycle after an abort.
  task automatic run_op(input bit hold, input int abort_at);
    int i, ex_h, ex_v;
    chk("idle_before_start", busy, 1'b0);
    drv_bx   = 8'(op_bx);
    drv_by   = 8'(op_by);
    drv_mask = op_mask;
    for (int p = 0; p < 16; p++) drv_pix[p] = 9'(op_pix[p]);
    start = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      next_cycle();
      if (k <= 16) begin
        i = k - 1;
        chk("busy_write", busy, 1'b1);
        chk("done_early", done, 1'b0);
        chk("we", mem_we, op_mask[i]);
        if (op_mask[i]) begin
          ex_h = (op_bx * 4 + i % 4) % 1024;
          ex_v = (op_by * 4 + i / 4) % 1024;
          chk("hcount", mem_hcount, ex_h);
          chk("vcount", mem_vcount, ex_v);
          chk("data", mem_data, op_pix[i]);
        end
      end else begin
        chk("done_pulse", done, 1'b1);
        chk("busy_done", busy, 1'b1);
        chk("we_done", mem_we, 1'b0);
      end
      scramble();
      start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (k == abort_at) begin
        reset = 1'b1;
        start = 1'b1;
        next_cycle();
        reset = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_we", mem_we, 1'b0);
        chk("abort_done", done, 1'b0);
        repeat (18) begin
          next_cycle();
          chk("abort_no_done", done, 1'b0);
          chk("abort_no_we", mem_we, 1'b0);
        end
        return;
      end
    end
    next_cycle();
  endtask

  task automatic idle_check();
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_we", mem_we, 1'b0);
    start = 1'b0;
    next_cycle();
    chk("no_queued_start", busy, 1'b0);
    chk("no_second_done", done, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b1;
    scramble();
    repeat (3) next_cycle();
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_we", mem_we, 1'b0);
    reset = 1'b0;
    start = 1'b0;
    next_cycle();
    chk("post_reset_busy", busy, 1'b0);

    // Coordinates (2,3), pixels 1..16, all enabled.
    op_bx = 2; op_by = 3; op_mask = 16'hFFFF;
    for (int i = 0; i < 16; i++) op_pix[i] = i + 1;
    run_op(1'b0, 0);
    idle_check();

    // Only corner pixels enabled.
    rand_op();
    op_mask = 16'h8001;
    run_op(1'b0, 0);
    idle_check();

    // Nothing enabled: still a full-length operation.
    rand_op();
    op_mask = 16'h0000;
    run_op(1'b0, 0);
    idle_check();

    // Frame edge coordinates wrap at ADDR_W.
    rand_op();
    op_bx = 255; op_by = 255; op_mask = 16'hFFFF;
    run_op(1'b0, 0);
    idle_check();

    // Start held high chains back-to-back blocks.
    rand_op();
    run_op(1'b1, 0);
    rand_op();
    run_op(1'b1, 0);
    idle_check();

    // Reset after the fifth write, then a clean block.
    rand_op();
    op_mask = 16'hFFFF;
    run_op(1'b0, 5);
    rand_op();
    run_op(1'b0, 0);
    idle_check();

    for (int n = 0; n < 24; n++) begin
      bit hold;
      int abort_at;
      hold     = ($urandom_range(0, 3) == 0);
      abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 16) : 0;
      rand_op();
      run_op(hold, abort_at);
      if (!hold) idle_check();
    end
    idle_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
